// File: rtl/replay_buffer_gen.sv
// replay_buffer_gen: data-link replay buffer; entries tagged with sequence numbers,
// purged on ACK/NAK, replayed in order on NAK or timeout. Stats via REPLAY_BUFFER_GEN_STATS_EN.
module replay_buffer_gen #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 16,
    parameter  int SEQ_W  = 12,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [DATA_W-1:0] din,
    output logic              wr_ready,
    output logic [SEQ_W-1:0]  wr_seq,
    input  logic [1:0]        ack_nack,
    input  logic [SEQ_W-1:0]  seq,
    input  logic              tim_out,
    input  logic              busy_n,
    output logic [DATA_W-1:0] dout,
    output logic [SEQ_W-1:0]  dout_seq,
    output logic              ready,
    output logic              replay_active,
    output logic              replay_rollover,
    output logic [AW:0]       count,
    output logic              empty
`ifdef REPLAY_BUFFER_GEN_STATS_EN
    ,
    output logic [15:0]       replay_total,
    output logic [7:0]        stale_ack
`endif
);

    localparam int EW   = SEQ_W + DATA_W;
    localparam int CNTW = AW + 1;
    localparam int CW   = (SEQ_W > CNTW) ? SEQ_W : CNTW;

    typedef enum logic {S_IDLE = 1'b0, S_REPLAY = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [SEQ_W-1:0]  r_next_seq;
    logic [1:0]        r_replay_num;
    logic              r_ready;
    logic              r_rollover;
    logic [DATA_W-1:0] r_dout;
    logic [SEQ_W-1:0]  r_dout_seq;

    logic [AW-1:0]     w_tail_nxt;
    logic [AW-1:0]     w_rd_nxt;
    logic [AW-1:0]     w_rd_adv;
    logic [AW-1:0]     w_off;
    logic [AW:0]       w_count_nxt;
    logic [AW:0]       w_pn;
    logic [1:0]        w_num_nxt;
    logic              w_ready_nxt;
    logic              w_roll_nxt;
    logic              w_load;
    logic              w_start;
    logic              w_wr;
    logic              w_ackn;
    logic              w_purge;
    logic              w_consume;
    logic              w_last;
    logic [SEQ_W-1:0]  w_tail_seq;
    logic [SEQ_W-1:0]  w_n;

    assign w_wr       = we & wr_ready;
    assign w_tail_seq = r_mem[r_tail][EW-1:DATA_W];
    assign w_n        = seq - w_tail_seq + SEQ_W'(1);
    assign w_ackn     = (ack_nack == 2'b01) || (ack_nack == 2'b10);
    assign w_purge    = w_ackn && (r_count != '0) && (w_n != '0)
                        && (CW'(w_n) <= CW'(r_count));
    assign w_pn       = w_purge ? CNTW'(w_n) : '0;
    assign w_consume  = r_ready & busy_n;
    assign w_last     = (r_rd_ptr == r_head - AW'(1));

    // Next-state and datapath next values: purge, replay start, replay stepping
    always_comb begin
        w_state_nxt = r_state;
        w_tail_nxt  = w_purge ? r_tail + AW'(w_n) : r_tail;
        w_count_nxt = r_count + CNTW'(w_wr) - w_pn;
        w_num_nxt   = w_purge ? 2'd0 : r_replay_num;
        w_rd_nxt    = r_rd_ptr;
        w_rd_adv    = r_rd_ptr;
        w_off       = '0;
        w_ready_nxt = r_ready;
        w_roll_nxt  = 1'b0;
        w_load      = 1'b0;
        w_start     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_ready_nxt = 1'b0;
                if ((w_count_nxt != '0) && ((ack_nack == 2'b10) || tim_out)) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_REPLAY;
                    w_rd_nxt    = w_tail_nxt;
                    w_roll_nxt  = (w_num_nxt == 2'd3);
                    w_num_nxt   = w_num_nxt + 2'd1;
                end
            end
            S_REPLAY: begin
                w_rd_adv = w_consume ? r_rd_ptr + AW'(1) : r_rd_ptr;
                w_off    = w_rd_adv - r_tail;
                if ((w_purge && (w_count_nxt == '0)) || (w_consume && w_last)) begin
                    w_state_nxt = S_IDLE;
                    w_ready_nxt = 1'b0;
                end else begin
                    w_rd_nxt = w_rd_adv;
                    if (w_purge && (CW'(w_off) < CW'(w_n)))
                        w_rd_nxt = w_tail_nxt;
                    w_load      = !r_ready || w_consume || (w_rd_nxt != w_rd_adv);
                    w_ready_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Pointers, counters and registered replay outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_next_seq   <= '0;
            r_replay_num <= '0;
            r_ready      <= 1'b0;
            r_rollover   <= 1'b0;
            r_dout       <= '0;
            r_dout_seq   <= '0;
        end else begin
            r_tail       <= w_tail_nxt;
            r_rd_ptr     <= w_rd_nxt;
            r_count      <= w_count_nxt;
            r_replay_num <= w_num_nxt;
            r_ready      <= w_ready_nxt;
            r_rollover   <= w_roll_nxt;
            if (w_wr) begin
                r_head     <= r_head + AW'(1);
                r_next_seq <= r_next_seq + SEQ_W'(1);
            end
            if (w_load) begin
                r_dout     <= r_mem[w_rd_nxt][DATA_W-1:0];
                r_dout_seq <= r_mem[w_rd_nxt][EW-1:DATA_W];
            end
        end
    end

    // Entry storage; contents survive reset
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_head] <= {r_next_seq, din};
    end

`ifdef REPLAY_BUFFER_GEN_STATS_EN
    logic [15:0] r_replay_total;
    logic [7:0]  r_stale_ack;

    // Saturating counts of replay starts and rejected ACK/NAKs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_replay_total <= '0;
            r_stale_ack    <= '0;
        end else begin
            if (w_start && (r_replay_total != 16'hFFFF))
                r_replay_total <= r_replay_total + 16'd1;
            if (w_ackn && !w_purge && (r_stale_ack != 8'hFF))
                r_stale_ack <= r_stale_ack + 8'd1;
        end
    end

    assign replay_total = r_replay_total;
    assign stale_ack    = r_stale_ack;
`endif

    assign wr_ready        = (r_state == S_IDLE) && (r_count < CNTW'(DEPTH));
    assign wr_seq          = r_next_seq;
    assign dout            = r_dout;
    assign dout_seq        = r_dout_seq;
    assign ready           = r_ready;
    assign replay_active   = (r_state == S_REPLAY);
    assign replay_rollover = r_rollover;
    assign count           = r_count;
    assign empty           = (r_count == '0);

endmodule
